// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the pipelined add/subtract unit.
//   - op_e           : operation select (OP_ADD / OP_SUB)
//   - SAT_*          : result handling modes for the SAT_MODE parameter
//   - ovf_test()     : two's-complement overflow test from operand/result MSBs
package arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned SAT_NONE     = 0;
  localparam int unsigned SAT_UNSIGNED = 1;
  localparam int unsigned SAT_SIGNED   = 2;

  // Overflow when both addends share a sign and the result's sign differs.
  // b_msb must be the MSB of the op-conditioned B operand.
  function automatic logic ovf_test(input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_chunk_stage.sv
// One pipeline slice of the carry-chained adder: adds a C-bit chunk of the
// operands plus the incoming carry and registers the chunk sum, carry-out
// and a valid bit.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   load      : stage advance enable (register empty or downstream takes it)
//   in_valid  : upstream beat present
//   a, b, cin : chunk operands (b already conditioned) and carry-in
//   valid     : registered beat-present flag
//   sum, cout : registered chunk sum and carry-out
module add_chunk_stage
  import arith_pkg::*;
#(
  parameter int unsigned C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         in_valid,
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic         valid,
  output logic [C-1:0] sum,
  output logic         cout
);

  logic [C:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        sum  <= total[C-1:0];
        cout <= total[C];
      end
    end
  end

endmodule

// File: rtl/pipe_add_sub_reg.sv
// Pipelined, registered add/subtract unit with valid/ready handshakes on
// both sides, bubble-collapsing back-pressure and optional saturation.
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready: operand beat handshake (a, b, op)
//   a, b             : WIDTH-bit operands
//   op               : 0 = A+B, 1 = A-B
//   out_valid/out_ready : result beat handshake
//   res              : result after saturation (SAT_MODE 0/1/2)
//   carry            : add carry-out / subtract no-borrow (A >= B unsigned)
//   ovf              : signed overflow of the raw result
// Each of the STAGES slices resolves one WIDTH/STAGES-bit chunk; a beat
// appears STAGES cycles after acceptance when the output is not stalled.
module pipe_add_sub_reg
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned SAT_MODE = SAT_NONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned C = WIDTH / STAGES;

  logic [WIDTH-1:0] b_cond;
  assign b_cond = (op == OP_SUB) ? ~b : b;

  // Stage k only keeps operand bits not yet consumed (REM - C bits) and the
  // sum bits already resolved below its chunk (k*C bits), so register widths
  // shrink/grow along the pipe instead of carrying full-width copies.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int unsigned REM = WIDTH - k * C;

    logic [REM-1:0]       a_in, b_in;
    logic                 op_in, vld_in, c_in;
    logic                 adv, ld, vld, c_out, op_q;
    logic [C-1:0]         s_q;
    logic [(k+1)*C-1:0]   done;

    if (k == 0) begin : g_in
      assign a_in   = a;
      assign b_in   = b_cond;
      assign op_in  = op;
      assign vld_in = in_valid;
      assign c_in   = op;
      assign done   = s_q;
    end else begin : g_in
      logic [k*C-1:0] lo_q;
      assign a_in   = stg[k-1].g_mid.a_q;
      assign b_in   = stg[k-1].g_mid.b_q;
      assign op_in  = stg[k-1].op_q;
      assign vld_in = stg[k-1].vld;
      assign c_in   = stg[k-1].c_out;
      assign done   = {s_q, lo_q};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) lo_q <= '0;
        else if (ld) lo_q <= stg[k-1].done;
      end
    end

    // Advance when empty or when the next stage (or the consumer) takes the
    // beat; this chain makes in_ready combinational from out_ready.
    if (k == STAGES - 1) begin : g_adv
      assign adv = ~vld | out_ready;
    end else begin : g_adv
      assign adv = ~vld | stg[k+1].adv;
    end

    assign ld = adv & vld_in;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) op_q <= 1'b0;
      else if (ld) op_q <= op_in;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [REM-C-1:0] a_q, b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_in[REM-1:C];
          b_q <= b_in[REM-1:C];
        end
      end
    end else begin : g_last
      // Operand MSBs kept for the overflow and signed-saturation decode.
      logic a_msb_q, b_msb_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (ld) begin
          a_msb_q <= a_in[C-1];
          b_msb_q <= b_in[C-1];
        end
      end
    end

    add_chunk_stage #(
      .C(C)
    ) u_chunk (
      .clk      (clk),
      .rst      (rst),
      .load     (adv),
      .in_valid (vld_in),
      .a        (a_in[C-1:0]),
      .b        (b_in[C-1:0]),
      .cin      (c_in),
      .valid    (vld),
      .sum      (s_q),
      .cout     (c_out)
    );
  end

  logic [WIDTH-1:0] raw;
  logic             a_msb, b_msb, op_last;

  assign raw       = stg[STAGES-1].done;
  assign a_msb     = stg[STAGES-1].g_last.a_msb_q;
  assign b_msb     = stg[STAGES-1].g_last.b_msb_q;
  assign op_last   = stg[STAGES-1].op_q;

  assign in_ready  = stg[0].adv;
  assign out_valid = stg[STAGES-1].vld;
  assign carry     = stg[STAGES-1].c_out;
  assign ovf       = ovf_test(a_msb, b_msb, raw[WIDTH-1]);

  // Saturation is decoded purely from last-stage registers, so res holds
  // steady whenever the final stage is not loading; flags stay raw.
  always_comb begin
    res = raw;
    case (SAT_MODE)
      SAT_UNSIGNED: begin
        if ((op_last == OP_ADD) && carry)       res = '1;
        else if ((op_last == OP_SUB) && !carry) res = '0;
      end
      SAT_SIGNED: begin
        if (ovf) res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_add_sub_reg.sv
module tb_pipe_add_sub_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, op;
  logic [15:0] a, b;
  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [15:0] res0, res1, res2;
  logic        carry0, carry1, carry2, ovf0, ovf1, ovf2;
  logic        iv3, or3, in_ready3, out_valid3, carry3, ovf3;
  logic [15:0] res3;

  always #5 clk = ~clk;

  pipe_add_sub_reg #(.WIDTH(16), .STAGES(4), .SAT_MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .op(op),
    .out_valid(out_valid0), .out_ready(out_ready), .res(res0), .carry(carry0), .ovf(ovf0));
  pipe_add_sub_reg #(.WIDTH(16), .STAGES(4), .SAT_MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b), .op(op),
    .out_valid(out_valid1), .out_ready(out_ready), .res(res1), .carry(carry1), .ovf(ovf1));
  pipe_add_sub_reg #(.WIDTH(16), .STAGES(4), .SAT_MODE(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .op(op),
    .out_valid(out_valid2), .out_ready(out_ready), .res(res2), .carry(carry2), .ovf(ovf2));
  pipe_add_sub_reg #(.WIDTH(16), .STAGES(1), .SAT_MODE(0)) d3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(in_ready3), .a(a), .b(b), .op(op),
    .out_valid(out_valid3), .out_ready(or3), .res(res3), .carry(carry3), .ovf(ovf3));

  typedef struct {
    logic [15:0] r0, r1, r2;
    logic        c, v;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  logic        acc, popped, chk_lat;
  logic [15:0] cap_r0, cap_r1, cap_r2;
  logic        cap_c, cap_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input logic o);
    exp_t e;
    int   ua, ub, sa, sbv, us, ss;
    ua  = int'(aa);
    ub  = int'(bb);
    sa  = int'($signed(aa));
    sbv = int'($signed(bb));
    if (o) begin
      us  = ua - ub;
      ss  = sa - sbv;
      e.c = (ua >= ub);
    end else begin
      us  = ua + ub;
      ss  = sa + sbv;
      e.c = (us > 65535);
    end
    e.r0  = us[15:0];
    e.v   = (ss > 32767) || (ss < -32768);
    e.r1  = (us > 65535) ? 16'hFFFF : ((us < 0) ? 16'h0000 : us[15:0]);
    e.r2  = (ss > 32767) ? 16'h7FFF : ((ss < -32768) ? 16'h8000 : ss[15:0]);
    e.acc = 0;
    return e;
  endfunction

  // One clock cycle: called right after a negedge with inputs set; samples
  // handshakes 1 time unit later and ends at the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    acc    = in_valid && in_ready0;
    popped = 1'b0;
    if (out_valid0) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out_valid", out_valid0, 0);
      end else begin
        e = sb[0];
        check_eq("res_wrap", res0, e.r0);
        check_eq("res_usat", res1, e.r1);
        check_eq("res_ssat", res2, e.r2);
        check_eq("carry", carry0, e.c);
        check_eq("ovf", ovf0, e.v);
        check_eq("ovf_ssat", ovf2, e.v);
        if (out_ready) begin
          if (chk_lat) check_eq("latency", cyc - e.acc, 4);
          cap_r0 = res0; cap_r1 = res1; cap_r2 = res2; cap_c = carry0; cap_v = ovf0;
          popped = 1'b1;
          void'(sb.pop_front());
        end
      end
    end
    if (acc) begin
      e     = model(a, b, op);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic o, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic ec, input logic ev);
    int unsigned n = 0;
    a = aa; b = bb; op = o;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    cycle();
    check_eq({tag, "_accept"}, acc, 1);
    in_valid = 1'b0;
    cycle();
    while (!popped && n < 20) begin
      cycle();
      n++;
    end
    check_eq({tag, "_done"}, popped, 1);
    if (popped) begin
      check_eq({tag, "_r0"}, cap_r0, e0);
      check_eq({tag, "_r1"}, cap_r1, e1);
      check_eq({tag, "_r2"}, cap_r2, e2);
      check_eq({tag, "_c"}, cap_c, ec);
      check_eq({tag, "_v"}, cap_v, ev);
    end
  endtask

  task automatic s1_beat(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                         input logic o, input logic [15:0] er, input logic ec, input logic ev);
    a = aa; b = bb; op = o; iv3 = 1'b1;
    #1;
    check_eq({tag, "_pre_valid"}, out_valid3, 0);
    check_eq({tag, "_in_ready"}, in_ready3, 1);
    @(negedge clk);
    iv3 = 1'b0;
    #1;
    check_eq({tag, "_valid"}, out_valid3, 1);
    check_eq({tag, "_res"}, res3, er);
    check_eq({tag, "_c"}, carry3, ec);
    check_eq({tag, "_v"}, ovf3, ev);
    @(negedge clk);
    #1;
    check_eq({tag, "_no_dup"}, out_valid3, 0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] sweep_val(input logic [4:0] i);
    return (i < 16) ? {11'd0, i} : (16'hFFF0 + {12'd0, i[3:0]});
  endfunction

  initial begin
    int unsigned idx, guard, n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0;
    a = '0; b = '0; iv3 = 1'b0; or3 = 1'b1; chk_lat = 1'b0;
    acc = 1'b0; popped = 1'b0;
    cap_r0 = '0; cap_r1 = '0; cap_r2 = '0; cap_c = 1'b0; cap_v = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid0, 0);
    check_eq("rst_res", res0, 0);
    check_eq("rst_res_usat", res1, 0);
    check_eq("rst_carry", carry0, 0);
    check_eq("rst_ovf", ovf2, 0);
    check_eq("rst_s1_valid", out_valid3, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready0, 1);
    @(negedge clk);

    // Single-stage instance: one-cycle registered adder
    s1_beat("s1_add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    s1_beat("s1_add_sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    s1_beat("s1_sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Directed boundary vectors on the 4-stage instances (wrap/usat/ssat)
    directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
    directed("add_sovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    directed("sub_sovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    directed("sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // Back-to-back sweep, one beat per cycle
    idx = 0; guard = 0;
    out_ready = 1'b1; chk_lat = 1'b1;
    while (idx < 2048 && guard < 4000) begin
      a  = sweep_val(idx[4:0]);
      b  = sweep_val(idx[9:5]);
      op = idx[10];
      in_valid = 1'b1;
      cycle();
      if (acc) idx++;
      guard++;
    end
    check_eq("sweep_accepted", idx, 2048);
    check_eq("sweep_cycles", guard, 2048);
    drain("sweep");

    // Back-pressure: output stalled for 6 cycles while input streams
    out_ready = 1'b0; chk_lat = 1'b0; n = 0;
    for (int i = 0; i < 6; i++) begin
      a = 16'h1000 + 16'(n); b = 16'(n * 3); op = 1'b0; in_valid = 1'b1;
      cycle();
      if (acc) n++;
    end
    #1;
    check_eq("bp_in_ready", in_ready0, 0);
    check_eq("bp_held", n, 4);
    check_eq("bp_out_valid", out_valid0, 1);
    // Pop and push on a full pipe in the same cycle
    out_ready = 1'b1; a = 16'hA5A5; b = 16'h5A5A; op = 1'b1;
    cycle();
    check_eq("bp_full_push_pop", acc, 1);
    check_eq("bp_full_pop", popped, 1);
    drain("bp");

    // Random back-pressure, 1000 beats
    n = 0; guard = 0;
    while (n < 1000 && guard < 10000) begin
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (acc) n++;
      guard++;
    end
    check_eq("rand_accepted", n, 1000);
    drain("rand");

    // Reset with 3 beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0123 + 16'(i); b = 16'h0456; op = 1'b0; in_valid = 1'b1;
      cycle();
      check_eq("rstmid_accept", acc, 1);
    end
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    check_eq("rstmid_pre_valid", out_valid0, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_out_valid", out_valid0, 0);
    check_eq("rstmid_res", res0, 0);
    check_eq("rstmid_carry", carry0, 0);
    check_eq("rstmid_ovf", ovf0, 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rstmid_in_ready", in_ready0, 1);
    check_eq("rstmid_no_stale", out_valid0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    directed("post_rst", 16'h0005, 16'h0003, 1'b1, 16'h0002, 16'h0002, 16'h0002, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
